dragster_spi_engine: RTL and testbench

DRAGSTER_SPI_ENGINE -- requirements
Module: dragster_spi_engine

---
 rtl/dragster_spi_pkg.sv | 55 +++++
 rtl/dragster_spi_tick_gen.sv | 31 +++
 rtl/dragster_spi_engine.sv | 192 +++++++++++++++++++
 tb/tb_dragster_spi_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragster_spi_pkg.sv
// Shared definitions for the dragster SPI engine: FSM state encoding, slave
// target codes, parameter defaults, counter widths and small decode helpers.
package dragster_spi_pkg;

    // Parameter defaults
    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_HOLD  = 2;
    localparam int unsigned DEF_IDLE_GAP = 2;

    // Counter widths sized to the legal parameter maxima (255 / 15 / 16 bits)
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned PHASE_W    = 4;
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned STATE_W    = 3;

    // FSM state enumeration
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Slave target codes
    localparam logic [1:0] DEV0  = 2'b00;
    localparam logic [1:0] DEV1  = 2'b01;
    localparam logic [1:0] BCAST = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    // Active-low chip-select pattern for a target code
    function automatic logic [1:0] ss_decode(input logic [1:0] target);
        logic [1:0] sel;
        case (target)
            DEV0:    sel = 2'b10;
            DEV1:    sel = 2'b01;
            BCAST:   sel = 2'b00;
            default: sel = 2'b11;
        endcase
        return sel;
    endfunction

    // Reserved target, or a read aimed at the broadcast group
    function automatic logic is_rejected(input logic op_write, input logic [1:0] target);
        return (target == RSVD) || ((target == BCAST) && !op_write);
    endfunction

    // Serial frame, MSB shifted first: address byte, then data byte or zeros
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic op_write,
                                                          input logic [15:0] word);
        return op_write ? {word[7:0], word[15:8]} : {word[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/dragster_spi_tick_gen.sv
// spi_tick_gen: half-period tick for sclk. Counts CLK_DIV clk cycles while
// enabled and flags the last cycle of each half-period.
// Ports: clk, reset (sync, active-high), en (count enable, clears when low),
//        tick_c (combinational, high on the final cycle of a half-period).
module spi_tick_gen
    import dragster_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick_c
);

    logic [DIV_W-1:0] div_cnt;

    assign tick_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));

    // Half-period counter, restarts from zero whenever the shifter is idle
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dragster_spi_engine.sv
// dragster_spi_engine: single-frame SPI master (mode 0) for the configurator.
// A write sends a 16-bit frame; a read sends an address byte and captures
// one byte from miso. Bad targets are rejected without touching the bus.
// Ports: clk, reset (sync, active-high), start/operation/slave/tx_word
//        (request), busy/done/error/rx_data (status), sclk/mosi/miso/ss_n (SPI).
module dragster_spi_engine
    import dragster_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        operation,
    input  logic [1:0]  slave,
    input  logic [15:0] tx_word,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  rx_data,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [1:0]  ss_n
);

    state_t                  state,     state_nxt;
    logic [PHASE_W-1:0]      phase_cnt, phase_cnt_nxt;
    logic [BIT_W-1:0]        bit_cnt,   bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   tx_shift,  tx_shift_nxt;
    logic [7:0]              rx_shift,  rx_shift_nxt;
    logic                    op_q,      op_nxt;
    logic                    busy_nxt, done_nxt, error_nxt, sclk_nxt, mosi_nxt;
    logic [7:0]              rx_data_nxt;
    logic [1:0]              ss_n_nxt;
    logic                    shift_en;
    logic                    tick_c;

    assign shift_en = (state == ST_SHIFT);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (shift_en),
        .tick_c (tick_c)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            op_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            rx_data   <= 8'h00;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= 2'b11;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx_shift  <= tx_shift_nxt;
            rx_shift  <= rx_shift_nxt;
            op_q      <= op_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            rx_data   <= rx_data_nxt;
            sclk      <= sclk_nxt;
            mosi      <= mosi_nxt;
            ss_n      <= ss_n_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        bit_cnt_nxt   = bit_cnt;
        tx_shift_nxt  = tx_shift;
        rx_shift_nxt  = rx_shift;
        op_nxt        = op_q;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        rx_data_nxt   = rx_data;
        sclk_nxt      = sclk;
        mosi_nxt      = mosi;
        ss_n_nxt      = ss_n;

        case (state)
            ST_IDLE: begin
                // busy is only high here for the single cycle of a rejection
                busy_nxt = 1'b0;
                sclk_nxt = 1'b0;
                mosi_nxt = 1'b0;
                ss_n_nxt = 2'b11;
                if (start && !busy) begin
                    busy_nxt = 1'b1;
                    if (is_rejected(operation, slave)) begin
                        done_nxt  = 1'b1;
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt     = ST_SETUP;
                        op_nxt        = operation;
                        ss_n_nxt      = ss_decode(slave);
                        tx_shift_nxt  = build_frame(operation, tx_word);
                        mosi_nxt      = tx_shift_nxt[FRAME_BITS-1];
                        phase_cnt_nxt = '0;
                        bit_cnt_nxt   = '0;
                    end
                end
            end

            ST_SETUP: begin
                if (phase_cnt == PHASE_W'(CS_SETUP - 1)) begin
                    state_nxt     = ST_SHIFT;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt + PHASE_W'(1);
                end
            end

            ST_SHIFT: begin
                if (tick_c) begin
                    if (!sclk) begin
                        // Rising edge: sample miso
                        sclk_nxt     = 1'b1;
                        rx_shift_nxt = {rx_shift[6:0], miso};
                    end else begin
                        // Falling edge: mosi may only move while sclk is low
                        sclk_nxt = 1'b0;
                        if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            mosi_nxt      = 1'b0;
                            state_nxt     = ST_HOLD;
                            phase_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt  = bit_cnt + BIT_W'(1);
                            tx_shift_nxt = {tx_shift[FRAME_BITS-2:0], 1'b0};
                            mosi_nxt     = tx_shift[FRAME_BITS-2];
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (phase_cnt == PHASE_W'(CS_HOLD - 1)) begin
                    state_nxt     = ST_GAP;
                    phase_cnt_nxt = '0;
                    ss_n_nxt      = 2'b11;
                    done_nxt      = 1'b1;
                    // Last 8 sampled bits are the read data byte
                    if (!op_q) begin
                        rx_data_nxt = rx_shift;
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt + PHASE_W'(1);
                end
            end

            ST_GAP: begin
                if (phase_cnt == PHASE_W'(IDLE_GAP - 1)) begin
                    state_nxt     = ST_IDLE;
                    phase_cnt_nxt = '0;
                    busy_nxt      = 1'b0;
                end else begin
                    phase_cnt_nxt = phase_cnt + PHASE_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                sclk_nxt  = 1'b0;
                mosi_nxt  = 1'b0;
                ss_n_nxt  = 2'b11;
            end
        endcase
    end

endmodule

// File: tb/tb_dragster_spi_engine.sv
// Scoreboard bench for dragster_spi_engine: the driver pushes expected
// transaction outcomes, the monitor observes the SPI bus and done pulses.
module tb_dragster_spi_engine;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned CS_SETUP  = 2;
    localparam int unsigned CS_HOLD   = 2;
    localparam int unsigned IDLE_GAP  = 2;
    localparam int unsigned FRAME_LEN = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        operation = 1'b0;
    logic [1:0]  slave = 2'b00;
    logic [15:0] tx_word = 16'h0000;
    logic        busy, done, error, sclk, mosi, miso;
    logic [7:0]  rx_data;
    logic [1:0]  ss_n;

    dragster_spi_engine #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .slave     (slave),
        .tx_word   (tx_word),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rej;
        logic [1:0]  ss;
        logic [15:0] bits;
        logic [7:0]  rx;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  exp_rx   = 8'h00;
    logic [7:0]  miso_byte = 8'h00;
    logic [1:0]  ss_tab [4] = '{2'b10, 2'b01, 2'b00, 2'b11};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Slave model: presents the read byte MSB-first on bits 8..15, changing after sclk falls
    int   mbit = 0;
    logic m_prev = 1'b0;
    always @(negedge clk) begin
        if (ss_n == 2'b11) begin
            mbit   = 0;
            m_prev = 1'b0;
            miso   = 1'($urandom);
        end else begin
            if (m_prev && !sclk) mbit++;
            m_prev = sclk;
            if (mbit >= 8 && mbit < 16) miso = miso_byte[15 - mbit];
            else if (!sclk) miso = 1'($urandom);
        end
    end

    // Monitor: collects each frame and scores it when done pulses
    logic        in_frame = 1'b0, frame_seen = 1'b0;
    logic [1:0]  ss_first;
    logic        ss_ok, timing_ok, mosi_ok, prev_sclk, prev_mosi;
    logic [15:0] bits;
    int          low_cnt, nbits, run_len, exp_len;
    logic        bf_pending = 1'b0;
    int          bf_cyc = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            in_frame   = 1'b0;
            frame_seen = 1'b0;
            bf_pending = 1'b0;
        end else begin
            if (bf_pending && !busy) begin
                check("busy_fall_cycle", 32'(cyc), 32'(bf_cyc));
                bf_pending = 1'b0;
            end
            if (ss_n != 2'b11) begin
                if (!in_frame) begin
                    in_frame = 1'b1; frame_seen = 1'b1; ss_first = ss_n; ss_ok = 1'b1;
                    timing_ok = 1'b1; mosi_ok = 1'b1; low_cnt = 0; nbits = 0; bits = '0;
                    run_len = 0; prev_sclk = 1'b0; prev_mosi = mosi;
                end
                if (ss_n != ss_first) ss_ok = 1'b0;
                low_cnt++;
                if (sclk == prev_sclk) begin
                    run_len++;
                end else begin
                    if (sclk) begin
                        exp_len = (nbits == 0) ? int'(CS_SETUP + CLK_DIV) : int'(CLK_DIV);
                        if (run_len != exp_len) timing_ok = 1'b0;
                        if (nbits < 16) bits[15 - nbits] = mosi;
                        nbits++;
                    end else if (run_len != int'(CLK_DIV)) begin
                        timing_ok = 1'b0;
                    end
                    run_len = 1;
                end
                if (sclk && prev_sclk && (mosi != prev_mosi)) mosi_ok = 1'b0;
                prev_sclk = sclk;
                prev_mosi = mosi;
            end else begin
                if (in_frame) begin
                    if (prev_sclk || run_len != int'(CS_HOLD)) timing_ok = 1'b0;
                    in_frame = 1'b0;
                end
                check("idle_sclk_low", 32'(sclk), 32'd0);
            end

            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: done=1 with no transaction pending (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("error", 32'(error), 32'(e.rej));
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("busy_at_done", 32'(busy), 32'd1);
                    check("frame_present", 32'(frame_seen), 32'(!e.rej));
                    if (!e.rej) begin
                        check("ss_n_value", 32'(ss_first), 32'(e.ss));
                        check("ss_n_stable", 32'(ss_ok), 32'd1);
                        check("ss_low_cycles", 32'(low_cnt), 32'(FRAME_LEN));
                        check("bit_count", 32'(nbits), 32'd16);
                        check("mosi_bits", 32'(bits), 32'(e.bits));
                        check("sclk_timing", 32'(timing_ok), 32'd1);
                        check("mosi_stable_high", 32'(mosi_ok), 32'd1);
                    end
                    frame_seen = 1'b0;
                    bf_cyc     = cyc + (e.rej ? 1 : int'(IDLE_GAP));
                    bf_pending = 1'b1;
                end
            end else if (error) begin
                n_checks++; n_fail++;
                $display("FAIL error_without_done: error=1 done=0 (cycle %0d)", cyc);
            end
        end
    end

    // Builds the expected outcome of a request from the interface rules
    function automatic exp_t model(input logic op, input logic [1:0] slv,
                                   input logic [15:0] w, input int c);
        exp_t m;
        m.rej  = (slv == 2'b11) || (slv == 2'b10 && op == 1'b0);
        m.ss   = ss_tab[slv];
        m.bits = op ? {w[7:0], w[15:8]} : {w[7:0], 8'h00};
        m.rx   = exp_rx;
        m.done_cyc = c + 1 + (m.rej ? 0 : int'(FRAME_LEN));
        return m;
    endfunction

    task automatic wait_idle(output logic ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (busy !== 1'b0) begin
            if (++n > 2000) begin
                n_checks++; n_fail++;
                $display("FAIL wait_idle_timeout: busy=%b after %0d cycles", busy, n);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic op, input logic [1:0] slv, input logic [15:0] w,
                         input logic [7:0] mb);
        logic ok;
        exp_t m;
        wait_idle(ok);
        if (!ok) return;
        operation = op; slave = slv; tx_word = w; miso_byte = mb; start = 1'b1;
        if (!((slv == 2'b11) || (slv == 2'b10 && op == 1'b0)) && !op) exp_rx = mb;
        m = model(op, slv, w, cyc);
        sb_q.push_back(m);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic ok;
        int   c0, c2;
        exp_t m;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'h3);

        issue(1'b1, 2'b00, 16'h3B05, 8'h00);
        issue(1'b0, 2'b01, 16'h0083, 8'hA5);
        issue(1'b1, 2'b11, 16'h1234, 8'h00);
        issue(1'b0, 2'b10, 16'h5678, 8'h00);
        issue(1'b1, 2'b10, 16'hA101, 8'h00);

        // start pulsed mid-frame must be ignored
        issue(1'b1, 2'b01, 16'h4C2D, 8'h00);
        repeat (9) @(negedge clk);
        operation = 1'b0; slave = 2'b00; tx_word = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // reset during bit 7 of a write aborts without done
        issue(1'b1, 2'b00, 16'h7E81, 8'h00);
        repeat (CS_SETUP + 14 * CLK_DIV + 2) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        exp_rx = 8'h00;
        @(negedge clk);
        check("abort_ss_n", 32'(ss_n), 32'h3);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 2'b00, 16'h1202, 8'h00);

        // start held high: two transactions, IDLE_GAP + one idle cycle apart
        wait_idle(ok);
        if (ok) begin
            operation = 1'b0; slave = 2'b01; tx_word = 16'h0042; miso_byte = 8'h3C;
            start = 1'b1;
            exp_rx = 8'h3C;
            c0 = cyc;
            m = model(1'b0, 2'b01, 16'h0042, c0);
            sb_q.push_back(m);
            c2 = m.done_cyc + int'(IDLE_GAP);
            m = model(1'b0, 2'b01, 16'h0042, c2);
            sb_q.push_back(m);
            while (cyc < c2 + 1) @(negedge clk);
            start = 1'b0;
        end

        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom), 2'($urandom), 16'($urandom), 8'($urandom));
        end

        for (int n = 0; n < 3000 && sb_q.size() != 0; n++) @(negedge clk);
        repeat (IDLE_GAP + 3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
